alu_cmd_issuer: RTL and testbench

- Initiator/driver side of the ALU operand interface: turns a stream of queued commands into cycle-accurate ALU stimulus and collects results.
- Buffers commands (op, a, b) from an upstream valid/ready port and issues them to alu_top one per cycle.
- Captures alu_out/zero_flag into a result FIFO that a downstream consumer drains via valid/ready.
- Owns alu_en for low-power gating: the ALU sleeps after an idle timeout and is woken before the next issue.

---
 rtl/alu_cmd_issuer.sv | 218 +++++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command issuer for the ALU operand interface: queues (op, a, b) commands, drives the ALU
// one op per cycle under result-FIFO credit, collects results in order and gates alu_en when idle.
module alu_cmd_issuer #(
    parameter int DATA_W       = 32,
    parameter int CMD_DEPTH    = 4,
    parameter int RES_DEPTH    = 4,
    parameter int IDLE_TIMEOUT = 4,
    parameter int WAKE_CYC     = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_err,
    output logic              alu_en,
    output logic [3:0]        control_signal,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              zero_flag,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; ready never looks at valid.

    localparam int CW = $clog2(CMD_DEPTH);
    localparam int RW = $clog2(RES_DEPTH);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int WW = $clog2(WAKE_CYC + 1);

    localparam logic [CW:0]   CMD_FULL = (CW + 1)'(CMD_DEPTH);
    localparam logic [CW:0]   CMD_ONE  = (CW + 1)'(1);
    localparam logic [CW-1:0] CPTR_ONE = CW'(1);
    localparam logic [RW:0]   RES_ONE  = (RW + 1)'(1);
    localparam logic [RW-1:0] RPTR_ONE = RW'(1);
    localparam logic [RW+1:0] RES_CAP  = (RW + 2)'(RES_DEPTH);
    localparam logic [IW-1:0] IDLE_END = IW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_ONE = IW'(1);
    localparam logic [WW-1:0] WAKE_END = WW'(WAKE_CYC - 1);
    localparam logic [WW-1:0] WAKE_ONE = WW'(1);

    typedef enum logic [1:0] {
        ST_SLEEP  = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       idle_q;
    logic [WW-1:0]       wake_q;
    logic                alu_en_q;
    logic [3:0]          cs_q;
    logic [DATA_W-1:0]   in0_q, in1_q;
    logic                iss_v_q, iss_err_q, cap_v_q, cap_err_q;

    logic [3:0]          cmd_op_mem [CMD_DEPTH];
    logic [DATA_W-1:0]   cmd_a_mem  [CMD_DEPTH];
    logic [DATA_W-1:0]   cmd_b_mem  [CMD_DEPTH];
    logic [CW-1:0]       cmd_wr_q, cmd_rd_q;
    logic [CW:0]         cmd_cnt_q, cmd_cnt_d;

    logic [DATA_W+1:0]   res_mem [RES_DEPTH];
    logic [RW-1:0]       res_wr_q, res_rd_q;
    logic [RW:0]         res_cnt_q, res_cnt_d;

    logic                cmd_empty, cmd_push, issue_window, credit_ok, head_legal, do_issue;
    logic                res_push, res_pop;
    logic [RW+1:0]       committed;
    logic [3:0]          head_op;
    logic [DATA_W+1:0]   res_in, res_head;

    assign cmd_empty    = (cmd_cnt_q == '0);
    assign cmd_ready    = clear && (cmd_cnt_q != CMD_FULL);
    assign cmd_push     = cmd_valid && cmd_ready;
    assign head_op      = cmd_op_mem[cmd_rd_q];
    assign head_legal   = (head_op <= 4'd9);

    // Every slot already promised to the result FIFO (stored + on the bus + being captured).
    assign committed    = {1'b0, res_cnt_q} + {{(RW + 1){1'b0}}, iss_v_q} + {{(RW + 1){1'b0}}, cap_v_q};
    assign credit_ok    = (committed < RES_CAP);
    // The last WAKE cycle may already decide an issue so the op reaches the bus on the first ACTIVE cycle.
    assign issue_window = (state_q == ST_ACTIVE) || ((state_q == ST_WAKE) && (wake_q == WAKE_END));
    assign do_issue     = issue_window && !cmd_empty && credit_ok;

    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        if (cmd_push && !do_issue) cmd_cnt_d = cmd_cnt_q + CMD_ONE;
        else if (!cmd_push && do_issue) cmd_cnt_d = cmd_cnt_q - CMD_ONE;
    end

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_op_mem[cmd_wr_q] <= cmd_op;
            cmd_a_mem[cmd_wr_q]  <= cmd_a;
            cmd_b_mem[cmd_wr_q]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
        end else begin
            if (cmd_push) cmd_wr_q <= cmd_wr_q + CPTR_ONE;
            if (do_issue) cmd_rd_q <= cmd_rd_q + CPTR_ONE;
            cmd_cnt_q <= cmd_cnt_d;
        end
    end

    // Illegal ops ride the same two-stage slot as real ops so results stay in command order.
    assign res_push = cap_v_q;
    assign res_in   = cap_err_q ? {1'b1, 1'b1, {DATA_W{1'b0}}} : {1'b0, zero_flag, alu_out};
    assign res_pop  = res_valid && res_ready;
    assign res_head = res_mem[res_rd_q];

    always_comb begin
        res_cnt_d = res_cnt_q;
        if (res_push && !res_pop) res_cnt_d = res_cnt_q + RES_ONE;
        else if (!res_push && res_pop) res_cnt_d = res_cnt_q - RES_ONE;
    end

    always_ff @(posedge clk) begin
        if (res_push) res_mem[res_wr_q] <= res_in;
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
        end else begin
            if (res_push) res_wr_q <= res_wr_q + RPTR_ONE;
            if (res_pop)  res_rd_q <= res_rd_q + RPTR_ONE;
            res_cnt_q <= res_cnt_d;
        end
    end

    assign res_valid = (res_cnt_q != '0);
    assign res_data  = res_valid ? res_head[DATA_W-1:0] : '0;
    assign res_zero  = res_valid && res_head[DATA_W];
    assign res_err   = res_valid && res_head[DATA_W+1];

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q   <= ST_SLEEP;
            idle_q    <= '0;
            wake_q    <= '0;
            alu_en_q  <= 1'b0;
            cs_q      <= '0;
            in0_q     <= '0;
            in1_q     <= '0;
            iss_v_q   <= 1'b0;
            iss_err_q <= 1'b0;
            cap_v_q   <= 1'b0;
            cap_err_q <= 1'b0;
        end else begin
            iss_v_q   <= do_issue;
            iss_err_q <= do_issue && !head_legal;
            cap_v_q   <= iss_v_q;
            cap_err_q <= iss_err_q;
            if (do_issue && head_legal) begin
                cs_q  <= head_op;
                in0_q <= cmd_a_mem[cmd_rd_q];
                in1_q <= cmd_b_mem[cmd_rd_q];
            end
            case (state_q)
                ST_SLEEP: begin
                    if (!cmd_empty) begin
                        state_q  <= ST_WAKE;
                        alu_en_q <= 1'b1;
                        wake_q   <= '0;
                    end
                end
                ST_WAKE: begin
                    if (wake_q == WAKE_END) begin
                        state_q <= ST_ACTIVE;
                        idle_q  <= '0;
                    end else begin
                        wake_q <= wake_q + WAKE_ONE;
                    end
                end
                ST_ACTIVE: begin
                    if (do_issue) begin
                        idle_q <= '0;
                    end else if (!iss_v_q && !cap_v_q) begin
                        if (idle_q == IDLE_END) begin
                            state_q  <= ST_SLEEP;
                            alu_en_q <= 1'b0;
                            idle_q   <= '0;
                        end else begin
                            idle_q <= idle_q + IDLE_ONE;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_SLEEP;
                    alu_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_en         = alu_en_q;
    assign control_signal = cs_q;
    assign alu_in0        = in0_q;
    assign alu_in1        = in1_q;
    assign dbg_state_o    = state_q;
    assign busy           = (state_q != ST_SLEEP) || !cmd_empty || res_valid || iss_v_q || cap_v_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: a behavioural registered ALU sits on the operand interface,
// results are checked in command order against hand-computed values.
module tb_alu_cmd_issuer;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          clear;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [W-1:0]  cmd_a, cmd_b;
    logic          res_valid, res_ready;
    logic [W-1:0]  res_data;
    logic          res_zero, res_err;
    logic          alu_en;
    logic [3:0]    control_signal;
    logic [W-1:0]  alu_in0, alu_in1;
    logic [W-1:0]  alu_out = '0;
    logic          zero_flag = 1'b0;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [W+1:0] exp_q[$];

    alu_cmd_issuer dut (
        .clk(clk), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
        .res_err(res_err), .alu_en(alu_en), .control_signal(control_signal),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_out(alu_out), .zero_flag(zero_flag),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // ---- ALU model: result registered at the edge ending an enabled cycle ----
    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_en) begin
            alu_out   <= alu_f(control_signal, alu_in0, alu_in1);
            zero_flag <= (alu_f(control_signal, alu_in0, alu_in1) == '0);
        end
    end

    // ---- checker ----
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---- scoreboard: every consumed result must match the head of exp_q ----
    always @(negedge clk) begin
        if (clear && res_valid && res_ready) begin
            check("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("result", 64'({res_data, res_zero, res_err}), 64'(exp_q.pop_front()));
        end
    end

    // ---- drivers ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] e_data, input logic e_zero, input logic e_err);
        int guard;
        guard = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("cmd_ready_at_push", 64'(cmd_ready), 64'd1);
        exp_q.push_back({e_data, e_zero, e_err});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while ((busy || exp_q.size() != 0) && guard < 300) begin
            tick();
            guard++;
        end
        check(tag, 64'({busy, 1'(exp_q.size() != 0)}), 64'd0);
    endtask

    // ---- directed sequence ----
    initial begin
        int   guard;
        logic seen;

        clear     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b0;

        // Reset
        tick();
        check("rst_cmd_ready_low", 64'(cmd_ready), 64'd0);
        clear = 1'b1;
        #1;
        check("rst_cmd_ready_high", 64'(cmd_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_fields", 64'({res_data, res_zero, res_err}), 64'd0);
        check("rst_alu_en", 64'(alu_en), 64'd0);
        check("rst_alu_bus", 64'({control_signal, alu_in0, alu_in1}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state_sleep", 64'(dbg_state), 64'd0);

        // Single ADD: SLEEP -> WAKE (1 cycle) -> issue, then idle timeout back to sleep
        res_ready = 1'b1;
        push_cmd(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        check("t1_sleep_alu_en", 64'(alu_en), 64'd0);
        check("t1_no_early_res", 64'(res_valid), 64'd0);
        tick();
        check("t1_wake_alu_en", 64'(alu_en), 64'd1);
        check("t1_wake_state", 64'(dbg_state), 64'd1);
        tick();
        check("t1_bus", 64'({control_signal, alu_in0}), {28'd0, 4'd0, 32'hFFFF_FFFF});
        check("t1_bus_in1", 64'(alu_in1), 64'h1);
        tick();
        check("t1_res_not_yet", 64'(res_valid), 64'd0);
        tick();
        check("t1_res_valid", 64'(res_valid), 64'd1);
        repeat (3) tick();
        check("t1_awake_before_timeout", 64'(alu_en), 64'd1);
        tick();
        check("t1_asleep_after_timeout", 64'(alu_en), 64'd0);
        repeat (3) tick();
        check("t1_bus_held_asleep", 64'({alu_in0, alu_in1}), {32'hFFFF_FFFF, 32'h0000_0001});
        wait_idle("t1_idle");

        // Four back-to-back commands, results on consecutive cycles
        push_cmd(4'd1, 32'd5,          32'd3,          32'h0000_0002, 1'b0, 1'b0);
        push_cmd(4'd1, 32'd12,         32'd15,         32'hFFFF_FFFD, 1'b0, 1'b0);
        push_cmd(4'd1, 32'd10,         32'd10,         32'h0000_0000, 1'b1, 1'b0);
        push_cmd(4'd2, 32'hAAAA_AAAA,  32'h5555_5555,  32'h0000_0000, 1'b1, 1'b0);
        guard = 0;
        while (!res_valid && guard < 50) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 4; i++) begin
            check("t2_res_stream", 64'(res_valid), 64'd1);
            tick();
        end
        check("t2_stream_end", 64'(res_valid), 64'd0);
        wait_idle("t2_idle");

        // Back-pressure: credit caps issue at 4, command FIFO then fills
        res_ready = 1'b0;
        push_cmd(4'd0, 32'd1,          32'd2,          32'h0000_0003, 1'b0, 1'b0);
        push_cmd(4'd0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 1'b0, 1'b0);
        push_cmd(4'd1, 32'd0,          32'd1,          32'hFFFF_FFFF, 1'b0, 1'b0);
        push_cmd(4'd2, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0, 1'b0, 1'b0);
        push_cmd(4'd3, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678, 1'b0, 1'b0);
        push_cmd(4'd1, 32'd100,        32'd100,        32'h0000_0000, 1'b1, 1'b0);
        push_cmd(4'd0, 32'h10,         32'h20,         32'h0000_0030, 1'b0, 1'b0);
        push_cmd(4'd2, 32'hFFFF_0000,  32'h0000_FFFF,  32'h0000_0000, 1'b1, 1'b0);
        check("t3_cmd_full", 64'(cmd_ready), 64'd0);
        check("t3_res_held", 64'(res_valid), 64'd1);
        repeat (12) tick();
        check("t3_still_stalled", 64'({cmd_ready, res_valid}), 64'b01);
        check("t3_results_kept", 64'(exp_q.size()), 64'd8);
        res_ready = 1'b1;
        wait_idle("t3_drain");
        check("t3_asleep", 64'(alu_en), 64'd0);
        check("t3_last_bus", 64'({alu_in0, alu_in1}), {32'hFFFF_0000, 32'h0000_FFFF});
        repeat (6) tick();
        check("t3_bus_constant", 64'({alu_in0, alu_in1}), {32'hFFFF_0000, 32'h0000_FFFF});
        check("t3_cs_constant", 64'(control_signal), 64'd2);

        // Illegal opcode between two legal ops
        push_cmd(4'd0, 32'd3,          32'd4,          32'h0000_0007, 1'b0, 1'b0);
        push_cmd(4'hF, 32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'h0000_0000, 1'b1, 1'b1);
        push_cmd(4'd0, 32'd5,          32'd6,          32'h0000_000B, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (alu_in0 == 32'hDEAD_BEEF || control_signal == 4'hF) seen = 1'b1;
            tick();
        end
        check("t5_illegal_not_driven", 64'(seen), 64'd0);
        check("t5_bus_after", 64'({alu_in0, alu_in1}), {32'd5, 32'd6});
        wait_idle("t5_idle");

        // Reset with 3 commands queued and 1 op in flight
        res_ready = 1'b0;
        push_cmd(4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        push_cmd(4'd0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
        push_cmd(4'd0, 32'd3, 32'd3, 32'd6, 1'b0, 1'b0);
        repeat (2) tick();
        guard = 0;
        while (alu_en && guard < 50) begin
            tick();
            guard++;
        end
        check("t6_pre_sleep", 64'(alu_en), 64'd0);
        push_cmd(4'd0, 32'd7, 32'd7, 32'd14, 1'b0, 1'b0);
        push_cmd(4'd1, 32'd9, 32'd1, 32'd8,  1'b0, 1'b0);
        push_cmd(4'd2, 32'd6, 32'd3, 32'd2,  1'b0, 1'b0);
        push_cmd(4'd3, 32'd4, 32'd1, 32'd5,  1'b0, 1'b0);
        clear = 1'b0;
        #1;
        check("t6_cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
        tick();
        check("t6_res_valid", 64'(res_valid), 64'd0);
        check("t6_alu_en", 64'(alu_en), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_outputs_zero", 64'({res_data, res_zero, res_err, control_signal}), 64'd0);
        check("t6_bus_zero", 64'({alu_in0, alu_in1}), 64'd0);
        exp_q.delete();
        clear     = 1'b1;
        res_ready = 1'b1;
        #1;
        check("t6_cmd_ready_after", 64'(cmd_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid || busy) seen = 1'b1;
            tick();
        end
        check("t6_no_stale_result", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
